cpu_debug_cmd_bridge: RTL
=========================

# cpu_debug_cmd_bridge

Parametrised system-clock side of the CPU JTAG debug slave. It synchronises the virtual-JTAG update strobes (UDR/UIR) into `clk` and captures the instruction register and shift register at each strobe. Captured commands are queued in a small FIFO and presented to the OCI debug logic over a valid/ready handshake, with per-instruction one-hot action pulses. It generalises the fixed 2-bit-IR, 38-bit, unbuffered take-action decoder: IR width, data width, synchroniser depth and queue depth are configurable, and it adds buffering, back-pressure and overflow reporting.

## Interface
Parameters:
- `DATA_W`, 38, width of the JTAG shift register `sr` and of `cmd_data`
- `IR_W`, 2, virtual IR width; the action vector has 2**IR_W bits
- `SYNC_STAGES`, 2, synchroniser flops per strobe; legal range 2..4
- `FIFO_DEPTH`, 4, command queue entries; power of two, >= 2

Ports:
- `clk`  in  1  system clock; the block's only clock
- `reset_n`  in  1  reset, synchronous and active-low
- `vs_udr`  in  1  virtual update-DR level from the TCK domain (asynchronous)
- `vs_uir`  in  1  virtual update-IR level from the TCK domain (asynchronous)
- `ir_in`  in  IR_W  virtual IR value; quasi-static, stable around each strobe
- `sr`  in  DATA_W  shift-register contents; quasi-static, stable around UDR
- `cmd_valid`  out  1  head of queue is valid
- `cmd_ready`  in  1  consumer accepts head
- `cmd_kind`  out  1  0 = UDR (data update), 1 = UIR (instruction update)
- `cmd_ir`  out  IR_W  IR captured with the head entry
- `cmd_data`  out  DATA_W  `sr` captured with the head entry (zero for UIR entries)
- `take_action`  out  2**IR_W  one-hot; bit `cmd_ir` is high when `cmd_valid & cmd_ready & ~cmd_kind`
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  occupied entries
- `overflow`  out  1  sticky; a strobe was dropped
- `overflow_clr`  in  1  clears `overflow`

## Operation
- **Synchronisers.** Each strobe passes through a `SYNC_STAGES` flop chain plus one history flop. A rising edge (sync output 1, history 0) is one event.
- **Arming counter.** It suppresses all events for `SYNC_STAGES`+1 cycles after reset release, so a strobe held high through reset produces no spurious event.
- **UDR event.** Pushes {kind=0, `ir_in`, `sr`}, sampled in the event cycle.
- **UIR event.** Pushes {kind=1, `ir_in`, 0}.
- **Simultaneous UDR and UIR events.** The UDR entry is pushed first. The UIR entry is held in a one-entry pending register and pushed the next cycle. A new UIR event while pending is set counts as a drop.
- **FIFO.** Circular buffer with read/write pointers and a count.
  - Push when full with no pop in the same cycle: entry dropped, `overflow` set, contents unchanged.
  - Push and pop in the same cycle when full: both occur, count unchanged.
  - Push and pop in the same cycle when empty: push only; `cmd_valid` rises the next cycle, with no bypass.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Handshake.** Pop occurs on `cmd_valid & cmd_ready`. `cmd_*` must hold stable while `cmd_valid` is high and `cmd_ready` is low. `cmd_valid` equals (`fifo_count` != 0).
- **Overflow flag.** `overflow_clr` has priority lower than a same-cycle overflow set, i.e. set wins.
- **Reset values.** All outputs are 0 after reset: `cmd_valid`, `cmd_kind`, `cmd_ir`, `cmd_data`, `take_action`, `fifo_count`, `overflow`. Pointers, pending register, synchroniser chains and history flops are also 0. A reset mid-operation discards queued entries and the pending register.

## Timing
- **Strobe-to-valid latency.** A strobe that rises and meets setup before edge 0 makes `cmd_valid` high after edge `SYNC_STAGES`+1 (edge 3 at default), provided the queue was empty.
- **Deferred UIR.** The UIR entry of a simultaneous pair reaches the FIFO one cycle after the UDR entry.
- **Throughput.** One push and one pop per cycle. `take_action` is combinational from the head and `cmd_ready`; it is a single-cycle pulse per accepted UDR entry.
- **Minimum strobe spacing.** Source strobes must be at least `SYNC_STAGES`+1 `clk` cycles high and low. Shorter pulses may be missed; missed pulses are not flagged.

## Test plan
- **Reset with strobe held high.** Hold `vs_udr`=1 through reset, release -> no `cmd_valid` for 20 cycles, `fifo_count`=0.
- **Single UDR.** `ir_in`=2, `sr`=38'h2A_DEADBEEF, pulse `vs_udr` with `cmd_ready`=1 -> `cmd_valid` at edge 3, `cmd_kind`=0, `cmd_data`=38'h2A_DEADBEEF, `take_action`=4'b0100 for one cycle.
- **Back-pressure and overflow.** `cmd_ready`=0, issue 5 UDRs with `sr`=1..5 -> `fifo_count`=4, `overflow`=1. Then raise `cmd_ready` -> data 1,2,3,4 in order; `overflow` stays 1 until `overflow_clr`.
- **Simultaneous strobes.** `vs_udr` and `vs_uir` rise together, `ir_in`=1 -> entry {0,1,sr} then entry {1,1,0}, one cycle apart.
- **Full with concurrent push and pop.** Queue full, `cmd_ready`=1 at the cycle a new event is pushed -> `fifo_count` stays 4, `overflow` stays 0, pointer wrap verified across 3 full cycles.
- **Mid-operation reset.** Assert `reset_n`=0 with 3 queued entries -> all outputs 0 on the next edge; no stale entries after release.

Source files
------------

// File: rtl/cpu_debug_cmd_bridge.sv
// cpu_debug_cmd_bridge
// System-clock side of the CPU JTAG debug slave. Synchronises the virtual-JTAG
// update strobes into clk, captures IR / shift register at each strobe, queues
// the resulting commands and hands them to the OCI debug logic over valid/ready.
//
// Ports
//   clk, reset_n           system clock, synchronous active-low reset
//   vs_udr, vs_uir         asynchronous update-DR / update-IR levels (TCK domain)
//   ir_in, sr              quasi-static virtual IR and shift-register contents
//   cmd_valid/cmd_ready    head-of-queue handshake
//   cmd_kind/cmd_ir/cmd_data  head entry (kind 0 = UDR, 1 = UIR)
//   take_action            one-hot pulse on bit cmd_ir for each accepted UDR entry
//   fifo_count             occupied queue entries
//   overflow/overflow_clr  sticky dropped-strobe flag and its clear
module cpu_debug_cmd_bridge #(
    parameter int unsigned DATA_W      = 38,
    parameter int unsigned IR_W        = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          vs_udr,
    input  logic                          vs_uir,
    input  logic [IR_W-1:0]               ir_in,
    input  logic [DATA_W-1:0]             sr,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic                          cmd_kind,
    output logic [IR_W-1:0]               cmd_ir,
    output logic [DATA_W-1:0]             cmd_data,
    output logic [(2**IR_W)-1:0]          take_action,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int unsigned ENTRY_W    = 1 + IR_W + DATA_W;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned ARM_W      = $clog2(ARM_CYCLES + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] udr_sync_q;
    logic [SYNC_STAGES-1:0] uir_sync_q;
    logic                   udr_hist_q;
    logic                   uir_hist_q;
    logic [ARM_W-1:0]       arm_cnt_q;
    logic [ARM_W-1:0]       arm_cnt_d;

    logic                   push_vld_q, push_vld_d;
    logic [ENTRY_W-1:0]     push_entry_q, push_entry_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [ENTRY_W-1:0]     pend_entry_q, pend_entry_d;

    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;

    // ------------------------------------------------------------------
    // Event detection
    // ------------------------------------------------------------------
    logic armed;
    logic ev_udr;
    logic ev_uir;
    logic drop_pend;

    // Events are masked until the chains have refilled after reset, so a
    // strobe held high across reset only loads the history flop.
    assign armed  = (arm_cnt_q == ARM_W'(ARM_CYCLES));
    assign ev_udr = armed & udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q;
    assign ev_uir = armed & uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q;

    always_comb begin
        arm_cnt_d = arm_cnt_q;
        if (!armed) begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end
    end

    // Push staging: UDR takes the push slot; a coincident UIR waits one cycle
    // in the pending register.
    always_comb begin
        push_vld_d   = 1'b0;
        push_entry_d = '0;
        pend_vld_d   = pend_vld_q;
        pend_entry_d = pend_entry_q;
        drop_pend    = 1'b0;
        if (ev_udr) begin
            push_vld_d   = 1'b1;
            push_entry_d = {1'b0, ir_in, sr};
            if (ev_uir) begin
                if (pend_vld_q) begin
                    drop_pend = 1'b1;
                end else begin
                    pend_vld_d   = 1'b1;
                    pend_entry_d = {1'b1, ir_in, {DATA_W{1'b0}}};
                end
            end
        end else if (pend_vld_q) begin
            push_vld_d   = 1'b1;
            push_entry_d = pend_entry_q;
            pend_vld_d   = 1'b0;
            if (ev_uir) begin
                drop_pend = 1'b1;
            end
        end else if (ev_uir) begin
            push_vld_d   = 1'b1;
            push_entry_d = {1'b1, ir_in, {DATA_W{1'b0}}};
        end
    end

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic               full;
    logic               pop;
    logic               do_push;
    logic               drop_full;
    logic [ENTRY_W-1:0] head;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop       = cmd_valid & cmd_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push   = push_vld_q & (~full | pop);
    assign drop_full = push_vld_q & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(pop);
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // Set beats a same-cycle clear.
    always_comb begin
        overflow_d = overflow_q;
        if (overflow_clr) begin
            overflow_d = 1'b0;
        end
        if (drop_full || drop_pend) begin
            overflow_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            udr_sync_q   <= '0;
            uir_sync_q   <= '0;
            udr_hist_q   <= 1'b0;
            uir_hist_q   <= 1'b0;
            arm_cnt_q    <= '0;
            push_vld_q   <= 1'b0;
            push_entry_q <= '0;
            pend_vld_q   <= 1'b0;
            pend_entry_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            udr_sync_q   <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
            uir_sync_q   <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            udr_hist_q   <= udr_sync_q[SYNC_STAGES-1];
            uir_hist_q   <= uir_sync_q[SYNC_STAGES-1];
            arm_cnt_q    <= arm_cnt_d;
            push_vld_q   <= push_vld_d;
            push_entry_q <= push_entry_d;
            pend_vld_q   <= pend_vld_d;
            pend_entry_q <= pend_entry_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_entry_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign head       = mem_q[rd_ptr_q];
    assign cmd_valid  = (count_q != '0);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

    // Head fields read as zero while the queue is empty.
    assign {cmd_kind, cmd_ir, cmd_data} = cmd_valid ? head : '0;

    always_comb begin
        take_action = '0;
        if (pop && !cmd_kind) begin
            take_action[cmd_ir] = 1'b1;
        end
    end

endmodule
